// File: rtl/mips_boot_loader_pkg.sv
// Shared definitions for the MIPS boot loader: FSM state encoding,
// header field widths and the default instruction memory depth.
package mips_boot_loader_pkg;

    localparam int CNT_W              = 8;
    localparam int BUDGET_W           = 8;
    localparam int IMEM_WORDS_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_HDR_CNT = 3'd0,
        ST_HDR_RUN = 3'd1,
        ST_LOAD    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RUN     = 3'd4,
        ST_HALT    = 3'd5,
        ST_ERROR   = 3'd6
    } boot_state_e;

endpackage

// File: rtl/mips_boot_loader_packer.sv
// Big-endian byte packer: collects four stream bytes into one 32-bit word
// and flags the transfer that completes the word.
module boot_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [1:0]  idx_q;
    logic [23:0] shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
        end else if (clear_i) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
        end else if (byte_valid_i) begin
            idx_q   <= idx_q + 2'd1;
            shift_q <= {shift_q[15:0], byte_i};
        end
    end

    // The completed word includes the byte being transferred this cycle.
    assign word_o      = {shift_q, byte_i};
    assign word_done_o = byte_valid_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/mips_boot_loader.sv
// Boot loader: parses a byte-stream header (word count, run budget), writes
// the image into instruction memory, then releases and supervises the core.
module mips_boot_loader
    import mips_boot_loader_pkg::*;
#(
    parameter int          IMEM_WORDS = IMEM_WORDS_DEFAULT,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        halted,
    output logic        err,
    output logic [31:0] cycle_cnt
);

    boot_state_e         state_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    widx_q;
    logic [BUDGET_W-1:0] budget_q;
    logic                rx_ready_q;
    logic                imem_we_q;
    logic [31:0]         imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic                core_rst_n_q;
    logic                halted_q;
    logic                err_q;
    logic [31:0]         cycle_cnt_q;

    logic                xfer;
    logic                pack_valid;
    logic                word_done;
    logic [31:0]         packed_word;
    logic [CNT_W-1:0]    widx_inc;
    logic [31:0]         budget_last;
    logic                count_bad;

    assign xfer        = rx_valid && rx_ready_q;
    assign pack_valid  = xfer && (state_q == ST_LOAD);
    assign widx_inc    = widx_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign budget_last = {{(32-BUDGET_W){1'b0}}, budget_q} - 32'd1;
    assign count_bad   = (rx_data == 8'd0) || (int'(rx_data) > IMEM_WORDS);

    boot_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (restart),
        .byte_valid_i (pack_valid),
        .byte_i       (rx_data),
        .word_o       (packed_word),
        .word_done_o  (word_done)
    );

    // rx_ready is registered, so it first rises one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HDR_CNT;
            count_q      <= '0;
            widx_q       <= '0;
            budget_q     <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= 32'd0;
            imem_wdata_q <= 32'd0;
            core_rst_n_q <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
            cycle_cnt_q  <= 32'd0;
        end else if (restart) begin
            state_q      <= ST_HDR_CNT;
            widx_q       <= '0;
            rx_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
            cycle_cnt_q  <= 32'd0;
        end else begin
            case (state_q)
                ST_HDR_CNT: begin
                    rx_ready_q <= 1'b1;
                    if (xfer) begin
                        count_q <= rx_data;
                        if (count_bad) begin
                            state_q    <= ST_ERROR;
                            err_q      <= 1'b1;
                            rx_ready_q <= 1'b0;
                        end else begin
                            state_q <= ST_HDR_RUN;
                        end
                    end
                end
                ST_HDR_RUN: begin
                    if (xfer) begin
                        budget_q <= rx_data;
                        state_q  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (word_done) begin
                        state_q      <= ST_WRITE;
                        rx_ready_q   <= 1'b0;
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= IMEM_BASE + {{(30-CNT_W){1'b0}}, widx_q, 2'b00};
                        imem_wdata_q <= packed_word;
                    end
                end
                ST_WRITE: begin
                    imem_we_q <= 1'b0;
                    widx_q    <= widx_inc;
                    if (widx_inc < count_q) begin
                        state_q    <= ST_LOAD;
                        rx_ready_q <= 1'b1;
                    end else begin
                        state_q      <= ST_RUN;
                        core_rst_n_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cycle_cnt_q != 32'hFFFF_FFFF) begin
                        cycle_cnt_q <= cycle_cnt_q + 32'd1;
                    end
                    // A zero budget means the core runs until restart or reset.
                    if ((budget_q != '0) && (cycle_cnt_q == budget_last)) begin
                        state_q      <= ST_HALT;
                        halted_q     <= 1'b1;
                        core_rst_n_q <= 1'b0;
                    end
                end
                ST_HALT, ST_ERROR: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= ST_HDR_CNT;
                end
            endcase
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign halted     = halted_q;
    assign err        = err_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: directed header/run scenarios
// plus randomized images compared against a word-list reference model.
module tb_mips_boot_loader;

    localparam int          IMEM_WORDS = 64;
    localparam logic [31:0] IMEM_BASE  = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        rxValid;
    logic [7:0]  rxData;
    logic        rxReady;
    logic        restartReq;
    logic        imemWe;
    logic [31:0] imemAddr;
    logic [31:0] imemWdata;
    logic        coreRstN;
    logic        haltedOut;
    logic        errOut;
    logic [31:0] cycleCnt;

    int          errorCount = 0;
    int          checkCount = 0;
    logic [31:0] imgWords[$];
    logic [31:0] seenAddr[$];
    logic [31:0] seenData[$];

    mips_boot_loader #(
        .IMEM_WORDS (IMEM_WORDS),
        .IMEM_BASE  (IMEM_BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rxValid),
        .rx_data    (rxData),
        .rx_ready   (rxReady),
        .restart    (restartReq),
        .imem_we    (imemWe),
        .imem_addr  (imemAddr),
        .imem_wdata (imemWdata),
        .core_rst_n (coreRstN),
        .halted     (haltedOut),
        .err        (errOut),
        .cycle_cnt  (cycleCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write strobe seen, one entry per high cycle.
    always @(negedge clk) begin
        if (rst_n && imemWe) begin
            seenAddr.push_back(imemAddr);
            seenData.push_back(imemWdata);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one byte until it is accepted; returns just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] b, input bit gaps);
        int budget = 400;
        bit sent   = 1'b0;
        while (!sent && budget > 0) begin
            budget--;
            @(negedge clk);
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                rxValid = 1'b0;
                rxData  = 8'($urandom);
                continue;
            end
            rxValid = 1'b1;
            rxData  = b;
            if (rxReady) sent = 1'b1;
        end
        if (!sent) checkOutput("byteTimeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rxValid = 1'b0;
    endtask

    task automatic pulseRestart();
        @(negedge clk);
        rxValid    = 1'b0;
        restartReq = 1'b1;
        @(posedge clk);
        #1;
        restartReq = 1'b0;
        checkOutput("rstErr", errOut, 1'b0);
        checkOutput("rstHalted", haltedOut, 1'b0);
        checkOutput("rstCnt", cycleCnt, 32'd0);
        checkOutput("rstCore", coreRstN, 1'b0);
        checkOutput("rstReady", rxReady, 1'b1);
    endtask

    task automatic loadImage(input int n, input int r, input bit gaps);
        seenAddr.delete();
        seenData.delete();
        applyStimulus(8'(n), gaps);
        applyStimulus(8'(r), gaps);
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                applyStimulus(8'(imgWords[w] >> (24 - 8 * b)), gaps);
            end
            checkOutput("weLatency", imemWe, 1'b1);
            checkOutput("weAddr", imemAddr, IMEM_BASE + 32'(4 * w));
            checkOutput("weData", imemWdata, imgWords[w]);
            checkOutput("readyInWrite", rxReady, 1'b0);
        end
    endtask

    task automatic verifyWrites(input int n);
        checkOutput("writeCount", seenAddr.size(), n);
        for (int i = 0; i < n && i < seenAddr.size(); i++) begin
            checkOutput("memAddr", seenAddr[i], IMEM_BASE + 32'(4 * i));
            checkOutput("memData", seenData[i], imgWords[i]);
        end
    endtask

    task automatic checkRun(input int r);
        @(posedge clk);
        #1;
        checkOutput("coreRelease", coreRstN, 1'b1);
        checkOutput("cntStart", cycleCnt, 32'd0);
        if (r != 0) begin
            repeat (r - 1) @(posedge clk);
            #1;
            checkOutput("cntBeforeHalt", cycleCnt, 32'(r - 1));
            checkOutput("notYetHalted", haltedOut, 1'b0);
            @(posedge clk);
            #1;
            checkOutput("haltFlag", haltedOut, 1'b1);
            checkOutput("haltCnt", cycleCnt, 32'(r));
            checkOutput("haltCore", coreRstN, 1'b0);
            repeat (5) @(posedge clk);
            #1;
            checkOutput("haltHold", cycleCnt, 32'(r));
        end
    endtask

    task automatic headerError(input int n);
        logic expErr;
        expErr = (n == 0) || (n > IMEM_WORDS);
        seenAddr.delete();
        seenData.delete();
        applyStimulus(8'(n), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("errFlag", errOut, expErr);
        checkOutput("errReady", rxReady, !expErr);
        checkOutput("errCore", coreRstN, 1'b0);
        checkOutput("errNoWrite", seenAddr.size(), 0);
    endtask

    task automatic randomImage(input int n);
        imgWords.delete();
        for (int i = 0; i < n; i++) imgWords.push_back($urandom);
    endtask

    initial begin
        int n;
        int r;
        rst_n      = 1'b0;
        rxValid    = 1'b0;
        rxData     = 8'd0;
        restartReq = 1'b0;
        #3;
        checkOutput("resetReady", rxReady, 1'b0);
        checkOutput("resetWe", imemWe, 1'b0);
        checkOutput("resetAddr", imemAddr, 32'd0);
        checkOutput("resetData", imemWdata, 32'd0);
        checkOutput("resetCore", coreRstN, 1'b0);
        checkOutput("resetHalted", haltedOut, 1'b0);
        checkOutput("resetErr", errOut, 1'b0);
        checkOutput("resetCnt", cycleCnt, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("readyBeforeEdge", rxReady, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("readyAfterEdge", rxReady, 1'b1);

        $display("[TB] two-word image, budget 17");
        imgWords = '{32'h2008_0005, 32'h2009_000A};
        loadImage(2, 8'h11, 1'b0);
        checkRun(17);
        verifyWrites(2);

        $display("[TB] illegal headers");
        pulseRestart();
        headerError(0);
        pulseRestart();
        headerError(65);
        pulseRestart();

        $display("[TB] full 64-word image");
        randomImage(64);
        loadImage(64, 3, 1'b0);
        checkRun(3);
        verifyWrites(64);
        checkOutput("lastAddr", seenAddr[seenAddr.size() - 1], IMEM_BASE + 32'h0000_00FC);

        $display("[TB] randomized images with and without valid gaps");
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 8);
            r = $urandom_range(1, 20);
            randomImage(n);
            pulseRestart();
            loadImage(n, r, 1'b1);
            checkRun(r);
            verifyWrites(n);
            pulseRestart();
            loadImage(n, r, 1'b0);
            checkRun(r);
            verifyWrites(n);
        end

        $display("[TB] restart during third byte of word 1");
        pulseRestart();
        randomImage(3);
        seenAddr.delete();
        seenData.delete();
        applyStimulus(8'd3, 1'b0);
        applyStimulus(8'd5, 1'b0);
        for (int b = 0; b < 4; b++) applyStimulus(8'(imgWords[0] >> (24 - 8 * b)), 1'b0);
        applyStimulus(8'(imgWords[1] >> 24), 1'b0);
        applyStimulus(8'(imgWords[1] >> 16), 1'b0);
        @(negedge clk);
        rxValid    = 1'b1;
        rxData     = 8'(imgWords[1] >> 8);
        restartReq = 1'b1;
        @(posedge clk);
        #1;
        restartReq = 1'b0;
        rxValid    = 1'b0;
        checkOutput("midCore", coreRstN, 1'b0);
        checkOutput("midWe", imemWe, 1'b0);
        checkOutput("midReady", rxReady, 1'b1);
        checkOutput("midWrites", seenAddr.size(), 1);
        randomImage(1);
        loadImage(1, 4, 1'b0);
        checkRun(4);
        verifyWrites(1);

        $display("[TB] unlimited budget and reset during run");
        pulseRestart();
        randomImage(1);
        loadImage(1, 0, 1'b0);
        checkRun(0);
        verifyWrites(1);
        repeat (310) @(posedge clk);
        #1;
        checkOutput("freeRunCnt", cycleCnt, 32'd310);
        checkOutput("freeRunHalted", haltedOut, 1'b0);
        checkOutput("freeRunCore", coreRstN, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncCore", coreRstN, 1'b0);
        checkOutput("asyncCnt", cycleCnt, 32'd0);
        checkOutput("asyncReady", rxReady, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rereleaseReady", rxReady, 1'b1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
